// File: rtl/credits_rotator_if.sv
// Control and display bundle for credits_rotator.
// The master drives enable, entry table and buttons; the slave returns the registered display outputs.
interface credits_rotator_if #(
    parameter int NUM_ENTRIES = 3,
    parameter int CHAR_W      = 5
);
    logic                            active;
    logic [NUM_ENTRIES*4*CHAR_W-1:0] entry_table;
    logic                            btn_next;
    logic                            btn_prev;
    logic                            btn_pause;
    logic [15:0]                     led;
    logic [4*CHAR_W-1:0]             seg_data;
    logic [3:0]                      dp_data;
    logic [2:0]                      entry_idx;

    modport master (
        output active, entry_table, btn_next, btn_prev, btn_pause,
        input  led, seg_data, dp_data, entry_idx
    );

    modport slave (
        input  active, entry_table, btn_next, btn_prev, btn_pause,
        output led, seg_data, dp_data, entry_idx
    );
endinterface

// File: rtl/credits_rotator.sv
// Cycles through NUM_ENTRIES four-character entries, DWELL_CYCLES clocks each, with pause and manual stepping.
// Define CREDITS_PROGRESS_EN to turn the LEDs into a dwell-progress thermometer bar.
module credits_rotator #(
    parameter int NUM_ENTRIES  = 3,
    parameter int DWELL_CYCLES = 300_000_000,
    parameter int CHAR_W       = 5
) (
    input  logic              clk,
    input  logic              reset,
    credits_rotator_if.slave  bus
);
    localparam int             ENTRY_W    = 4 * CHAR_W;
    localparam logic [28:0]    DWELL_LAST = 29'(DWELL_CYCLES - 1);
    localparam logic [2:0]     IDX_LAST   = 3'(NUM_ENTRIES - 1);

    generate
        if (NUM_ENTRIES < 2 || NUM_ENTRIES > 8) begin : g_bad_entries
            $error("credits_rotator: NUM_ENTRIES must be 2..8");
        end
        if (DWELL_CYCLES < 16 || DWELL_CYCLES > 536870911 || (DWELL_CYCLES % 16) != 0) begin : g_bad_dwell
            $error("credits_rotator: DWELL_CYCLES must be 16..2^29-1 and a multiple of 16");
        end
        if (CHAR_W < 1) begin : g_bad_char
            $error("credits_rotator: CHAR_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHOW, PAUSED} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           idx_reg, idx_next;
    logic [28:0]          cnt_reg, cnt_next;
    logic [15:0]          led_reg, led_next;
    logic [ENTRY_W-1:0]   seg_reg, seg_next;
    logic [3:0]           dp_reg, dp_next;
    logic                 restart, tick;

    // Padded to 8 so the 3-bit index always selects a defined slot.
    logic [ENTRY_W-1:0]   entries [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_entries
            if (gi < NUM_ENTRIES) begin : g_used
                assign entries[gi] = bus.entry_table[gi*ENTRY_W +: ENTRY_W];
            end else begin : g_unused
                assign entries[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        logic step_fwd, step_back, expired;
        logic [2:0] idx_inc, idx_dec;
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        restart    = 1'b0;
        tick       = 1'b0;
        step_fwd   = bus.btn_next & ~bus.btn_prev;
        step_back  = bus.btn_prev & ~bus.btn_next;
        expired    = (state_reg == SHOW) && (cnt_reg == DWELL_LAST);
        idx_inc    = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
        idx_dec    = (idx_reg == 3'd0) ? IDX_LAST : idx_reg - 3'd1;
        if (!bus.active) begin
            state_next = IDLE;
            idx_next   = 3'd0;
            cnt_next   = '0;
            restart    = 1'b1;
        end else if (state_reg == IDLE) begin
            state_next = SHOW;
        end else begin
            // A button step overrides a coinciding expiry rather than stacking with it.
            if (step_back) begin
                idx_next = idx_dec;
                cnt_next = '0;
                restart  = 1'b1;
            end else if (step_fwd || expired) begin
                idx_next = idx_inc;
                cnt_next = '0;
                restart  = 1'b1;
            end else if (state_reg == SHOW) begin
                cnt_next = cnt_reg + 29'd1;
                tick     = 1'b1;
            end
            if (bus.btn_pause) begin
                state_next = (state_reg == SHOW) ? PAUSED : SHOW;
            end
        end
    end

    always_comb begin
        seg_next = entries[idx_next];
        case (state_next)
            SHOW:    dp_next = 4'b1000;
            PAUSED:  dp_next = 4'b1001;
            default: dp_next = 4'b0000;
        endcase
    end

`ifdef CREDITS_PROGRESS_EN
    localparam logic [24:0] SUB_LAST = 25'(DWELL_CYCLES / 16 - 1);

    logic [24:0] sub_reg, sub_next;
    logic [3:0]  prog_reg, prog_next;

    always_comb begin
        sub_next  = sub_reg;
        prog_next = prog_reg;
        if (restart) begin
            sub_next  = '0;
            prog_next = '0;
        end else if (tick) begin
            if (sub_reg == SUB_LAST) begin
                sub_next  = '0;
                prog_next = prog_reg + 4'd1;
            end else begin
                sub_next = sub_reg + 25'd1;
            end
        end
    end

    generate
        for (gi = 0; gi < 16; gi++) begin : g_led_bar
            assign led_next[gi] = (state_next != IDLE) && (4'(gi) <= prog_next);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_reg  <= '0;
            prog_reg <= '0;
        end else begin
            sub_reg  <= sub_next;
            prog_reg <= prog_next;
        end
    end
`else
    generate
        for (gi = 0; gi < 16; gi++) begin : g_led_onehot
            if (gi < 8) begin : g_live
                assign led_next[gi] = (state_next != IDLE) && (idx_next == 3'(gi));
            end else begin : g_dark
                assign led_next[gi] = 1'b0;
            end
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            cnt_reg   <= '0;
            led_reg   <= '0;
            seg_reg   <= entries[0];
            dp_reg    <= 4'b0000;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            led_reg   <= led_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
        end
    end

    assign bus.led       = led_reg;
    assign bus.seg_data  = seg_reg;
    assign bus.dp_data   = dp_reg;
    assign bus.entry_idx = idx_reg;
endmodule

// File: tb/tb_credits_rotator.sv
// Directed bench for credits_rotator: a rule-level model is compared every cycle,
// and hand-computed literals pin free run, pause, navigation, reset and active-drop behaviour.
module tb_credits_rotator;
    localparam int N  = 3;
    localparam int D  = 16;
    localparam int CW = 5;
    localparam int EW = 4 * CW;
    localparam logic [19:0] E0 = 20'h08421;
    localparam logic [19:0] E1 = 20'h1294A;
    localparam logic [19:0] E2 = 20'h39CE7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    credits_rotator_if #(.NUM_ENTRIES(N), .CHAR_W(CW)) bus ();

    credits_rotator #(.NUM_ENTRIES(N), .DWELL_CYCLES(D), .CHAR_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = idle, 1 = showing, 2 = paused; age = cycles spent on the current entry.
    int m_mode = 0;
    int m_idx  = 0;
    int m_age  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int step;
        if (reset || !bus.active) begin
            m_mode = 0;
            m_idx  = 0;
            m_age  = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            step = 0;
            if (bus.btn_next && !bus.btn_prev) step = 1;
            else if (bus.btn_prev && !bus.btn_next) step = N - 1;
            if (step != 0) begin
                m_idx = (m_idx + step) % N;
                m_age = 0;
            end else if (m_mode == 1 && m_age == D - 1) begin
                m_idx = (m_idx + 1) % N;
                m_age = 0;
            end else if (m_mode == 1) begin
                m_age++;
            end
            if (bus.btn_pause) m_mode = 3 - m_mode;
        end
    endtask

    function automatic logic [31:0] exp_seg();
        return 32'(20'(bus.entry_table >> (m_idx * EW)));
    endfunction

    function automatic logic [31:0] exp_dp();
        return (m_mode == 1) ? 32'h8 : (m_mode == 2) ? 32'h9 : 32'h0;
    endfunction

    function automatic logic [31:0] exp_led();
        if (m_mode == 0) return 32'h0;
`ifdef CREDITS_PROGRESS_EN
        return ((32'd1 << (m_age / (D / 16) + 1)) - 32'd1) & 32'hFFFF;
`else
        return 32'd1 << m_idx;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_idx", 32'(bus.entry_idx), 32'(m_idx));
        check("model_seg", 32'(bus.seg_data), exp_seg());
        check("model_dp",  32'(bus.dp_data), exp_dp());
        check("model_led", 32'(bus.led), exp_led());
        $display("cycle t=%0t idx=%0d seg=%05h dp=%b led=%04h", $time, bus.entry_idx, bus.seg_data, bus.dp_data, bus.led);
        bus.btn_next  = 1'b0;
        bus.btn_prev  = 1'b0;
        bus.btn_pause = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset           = 1'b1;
        bus.active      = 1'b0;
        bus.btn_next    = 1'b0;
        bus.btn_prev    = 1'b0;
        bus.btn_pause   = 1'b0;
        bus.entry_table = {E2, E1, E0};

        run(2);
        check("rst_idx", 32'(bus.entry_idx), 32'd0);
        check("rst_seg", 32'(bus.seg_data), 32'(E0));
        check("rst_led", 32'(bus.led), 32'h0);
        check("rst_dp",  32'(bus.dp_data), 32'h0);

        // Free run: enter SHOW on the first edge, advance every 16 edges after that.
        reset      = 1'b0;
        bus.active = 1'b1;
        run(16);
        check("free_hold0", 32'(bus.entry_idx), 32'd0);
        run(1);
        check("free_idx1", 32'(bus.entry_idx), 32'd1);
        check("free_seg1", 32'(bus.seg_data), 32'(E1));
        check("free_dp",   32'(bus.dp_data), 32'h8);
`ifndef CREDITS_PROGRESS_EN
        check("free_led1", 32'(bus.led), 32'h0002);
`endif
        run(16);
        check("free_idx2", 32'(bus.entry_idx), 32'd2);
        check("free_seg2", 32'(bus.seg_data), 32'(E2));
`ifndef CREDITS_PROGRESS_EN
        check("free_led2", 32'(bus.led), 32'h0004);
`endif
        run(16);
        check("free_wrap", 32'(bus.entry_idx), 32'd0);
        check("free_seg0", 32'(bus.seg_data), 32'(E0));
        run(1);

        // Pause at dwell count 1 (count reaches 2 on the pause edge), hold 40 cycles, resume.
        bus.btn_pause = 1'b1;
        run(1);
        check("pause_dp", 32'(bus.dp_data), 32'h9);
        run(40);
        check("pause_idx", 32'(bus.entry_idx), 32'd0);
        check("pause_dp_hold", 32'(bus.dp_data), 32'h9);
        bus.btn_pause = 1'b1;
        run(1);
        check("resume_dp", 32'(bus.dp_data), 32'h8);
        run(13);
        check("resume_hold", 32'(bus.entry_idx), 32'd0);
        run(1);
        check("resume_adv", 32'(bus.entry_idx), 32'd1);

        // Navigation and wrap.
        bus.btn_prev = 1'b1;
        run(1);
        check("prev_1to0", 32'(bus.entry_idx), 32'd0);
        bus.btn_prev = 1'b1;
        run(1);
        check("prev_wrap", 32'(bus.entry_idx), 32'd2);
        check("prev_wrap_seg", 32'(bus.seg_data), 32'(E2));
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        run(1);
        check("both_ignored", 32'(bus.entry_idx), 32'd2);
        bus.btn_next = 1'b1;
        run(1);
        check("next_wrap", 32'(bus.entry_idx), 32'd0);
        run(15);
        bus.btn_next = 1'b1;
        run(1);
        check("next_on_expiry", 32'(bus.entry_idx), 32'd1);
        run(15);
        bus.btn_prev = 1'b1;
        run(1);
        check("prev_on_expiry", 32'(bus.entry_idx), 32'd0);

        // Reset at idx 2 with dwell count 9.
        bus.btn_prev = 1'b1;
        run(1);
        run(9);
        reset = 1'b1;
        run(1);
        check("midrst_idx", 32'(bus.entry_idx), 32'd0);
        check("midrst_seg", 32'(bus.seg_data), 32'(E0));
        check("midrst_led", 32'(bus.led), 32'h0);
        reset = 1'b0;
        run(16);
        check("midrst_hold", 32'(bus.entry_idx), 32'd0);
        run(1);
        check("midrst_adv", 32'(bus.entry_idx), 32'd1);

        // Pause and step together both apply.
        bus.btn_pause = 1'b1;
        bus.btn_next  = 1'b1;
        run(1);
        check("pause_step_idx", 32'(bus.entry_idx), 32'd2);
        check("pause_step_dp",  32'(bus.dp_data), 32'h9);

        // Drop active for one cycle while paused; a button in that cycle is ignored.
        bus.active   = 1'b0;
        bus.btn_next = 1'b1;
        run(1);
        check("drop_idx", 32'(bus.entry_idx), 32'd0);
        check("drop_dp",  32'(bus.dp_data), 32'h0);
        check("drop_led", 32'(bus.led), 32'h0);
        bus.active = 1'b1;
        run(1);
        check("drop_show_dp", 32'(bus.dp_data), 32'h8);
        run(15);
        check("drop_hold", 32'(bus.entry_idx), 32'd0);
        run(1);
        check("drop_adv", 32'(bus.entry_idx), 32'd1);

        // Table edit on the current entry shows up one cycle later without an index change.
        bus.entry_table[39:20] = 20'h0ABCD;
        run(1);
        check("table_edit", 32'(bus.seg_data), 32'h0ABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/credits_rotator.md
CREDITS_ROTATOR -- requirements
Module: credits_rotator

Interface
REQ-001 Parameters (name, default, meaning), one per line; reject out-of-range values at elaboration:
- NUM_ENTRIES, 3, number of display entries; legal range 2..8.
- DWELL_CYCLES, 300_000_000, clk cycles each entry is shown; legal range 16..2^29-1; multiple of 16.
- CHAR_W, 5, bits per character code.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, system clock (100 MHz).
- reset, input, 1, synchronous, active-high reset.
- active, input, 1, block enabled; low behaves as a soft reset.
- entry_table, input, NUM_ENTRIES*4*CHAR_W, entry k occupies bits [(k+1)*4*CHAR_W-1 : k*4*CHAR_W]; leftmost character is the MSB field.
- btn_next, input, 1, single-cycle pulse; advance one entry.
- btn_prev, input, 1, single-cycle pulse; go back one entry.
- btn_pause, input, 1, single-cycle pulse; toggle pause.
- led, output, 16, status LEDs (registered).
- seg_data, output, 4*CHAR_W, four character codes to the display driver (registered).
- dp_data, output, 4, decimal points, one per digit (registered).
- entry_idx, output, 3, current entry index (registered).

Function
REQ-003 States: IDLE (active=0), SHOW, PAUSED. IDLE->SHOW when active=1. SHOW<->PAUSED on btn_pause. Any state->IDLE when active=0.
REQ-004 Dwell counter: counts 0..DWELL_CYCLES-1 in SHOW only; holds its value in PAUSED; held at 0 in IDLE.
REQ-005 Expiry: when the counter equals DWELL_CYCLES-1 in SHOW, the counter returns to 0 and entry_idx advances by one on the same edge.
REQ-006 Index wrap: advancing from NUM_ENTRIES-1 goes to 0; going back from 0 goes to NUM_ENTRIES-1.
REQ-007 Manual navigation:
- btn_next or btn_prev in SHOW or PAUSED steps entry_idx by +1 or -1 and clears the dwell counter to 0.
- A manual step does not change the state (PAUSED stays PAUSED).
REQ-008 Simultaneous events:
- btn_next and btn_prev together: both ignored.
- A button step coinciding with expiry: exactly one step, in the button's direction.
- btn_pause together with a step: both take effect.
- All buttons are ignored in IDLE.
REQ-009 seg_data equals the entry_table slice for the new entry_idx on the same edge that entry_idx is updated (zero added latency). entry_table changes are reflected within 1 cycle even when the index does not change.
REQ-010 dp_data values:
- 4'b1000 in SHOW.
- 4'b1001 in PAUSED.
- 4'b0000 in IDLE.
REQ-011 led, base behaviour: led[entry_idx]=1 (one-hot); all other bits 0; all bits 0 in IDLE.

Reset
REQ-012 When reset=1 at a clk edge, or active=0, the block SHALL set:
- state to IDLE (or SHOW on the next edge if active=1 and reset=0).
- entry_idx=0 and dwell counter=0.
- seg_data to entry 0 of entry_table.
- led=0 and dp_data=0.
REQ-013 reset asserted mid-dwell or while PAUSED discards all progress and the pause flag. The first expiry after release occurs exactly DWELL_CYCLES cycles after entering SHOW.

Configuration
REQ-014 Macro CREDITS_PROGRESS_EN.
- When defined: a 4-bit progress counter increments every DWELL_CYCLES/16 cycles of dwell. led becomes a thermometer bar, with bits [p:0] lit for progress count p. The progress counter clears with the dwell counter (expiry, manual step, reset, IDLE).
- When undefined: REQ-011 applies and no progress logic is synthesised.

Verification (NUM_ENTRIES=3, DWELL_CYCLES=16, entries E0=0x08421, E1=0x1294A, E2=0x39CE7)
REQ-015 Free run: reset 2 cycles, then active=1 for 50 cycles. entry_idx goes 0->1 at cycle 16, ->2 at cycle 32, ->0 at cycle 48. seg_data matches E0/E1/E2 on the same edges. dp_data=4'b1000.
REQ-016 Pause: btn_pause at cycle 5, idle for 40 cycles, btn_pause again. No index change while paused and dp_data=4'b1001. After resume, the next advance comes 11 cycles later.
REQ-017 Navigation and wrap: btn_prev at idx 0 -> idx 2, counter 0. btn_next and btn_prev together -> no change. btn_next on an expiry cycle -> exactly one step.
REQ-018 Reset mid-operation: reset at idx 2 with counter 9. Next edge: idx 0, seg_data=E0, led=0. The first advance comes 16 cycles after release.
REQ-019 active drop: active=0 for 1 cycle while PAUSED. Result: IDLE, outputs cleared, pause lost; SHOW resumes at idx 0.
REQ-020 With CREDITS_PROGRESS_EN: led=16'h0001 at dwell count 0, and gains one bit per cycle up to 16'hFFFF at count 15. Without the macro: led=16'h0001/0002/0004 for idx 0/1/2.
